sort_engine: RTL and testbench
==============================

// Module: sort_engine
// PURPOSE
//   Parametrised in-memory bubble-sort engine with early exit. Sorts N words held in a single-port RAM.
//   Memory layout: word 0 holds the count N; elements occupy addresses 1..N.
//   Adds ascending/descending and signed/unsigned compare modes, plus cycle and swap statistics.
//   The RAM is external to the block. A debug/loader port owns the RAM whenever the engine is not busy.
// PARAMETERS
//   DW  32  data word width
//   AW   9  RAM address width; N is taken from mem word 0 bits [AW-1:0]
//   CW  16  width of the cycles and swaps counters
// PORTS
//   clk        in   1   clock
//   rstn       in   1   asynchronous reset, active-high
//   start      in   1   level input; internal rising-edge detect launches a sort
//   descend    in   1   0: ascending, 1: descending; sampled on the start edge
//   is_signed  in   1   0: unsigned compare, 1: two's-complement compare; sampled on the start edge
//   busy       out  1   engine owns the RAM (all states except IDLE and DONE)
//   done       out  1   high in DONE state only
//   cycles     out  CW  clocks spent busy, saturating
//   swaps      out  CW  element swaps performed, saturating
//   mem_addr   out  AW  RAM address
//   mem_wdata  out  DW  RAM write data
//   mem_we     out  1   RAM write enable
//   mem_rdata  in   DW  RAM asynchronous read data
//   dbg_addr   in   AW  debug address
//   dbg_wdata  in   DW  debug write data
//   dbg_we     in   1   debug write enable
//   dbg_rdata  out  DW  equals mem_rdata at all times
// BEHAVIOUR
// - Reset: state=IDLE. busy, done, cycles, swaps, mem_we, internal j/hi/A/B/swapped and start_d are all 0.
//   RAM contents are not touched; a reset mid-sort leaves the array partially sorted.
// - Start edge: start & ~start_d, with start_d registered each clk. The edge is honoured only in IDLE or DONE.
//   It is ignored while busy. The edge latches descend and is_signed, then moves to LOADN.
// - RAM mux: busy=1 -> mem_* are driven by the FSM; dbg_we is ignored.
//   busy=0 -> mem_addr=dbg_addr, mem_wdata=dbg_wdata, mem_we=dbg_we.
// - FSM, one state per clk:
//   LOADN : addr=0; N<=rdata[AW-1:0]; cycles<=0; swaps<=0.
//           N<=1 -> DONE; else hi<=N, go PASS.
//   PASS  : j<=1; swapped<=0 -> RD_A.
//   RD_A  : addr=j;   A<=rdata -> RD_B.
//   RD_B  : addr=j+1; B<=rdata -> CMP.
//   CMP   : ooo = descend ? (A<B) : (A>B), using the latched signedness. ooo -> WR_A; else NEXT.
//   WR_A  : addr=j;   wdata=B; we=1 -> WR_B.
//   WR_B  : addr=j+1; wdata=A; we=1; swapped<=1; swaps++ -> NEXT.
//   NEXT  : if j+1<hi: j<=j+1 -> RD_A.
//           else (end of pass): hi<=hi-1; if swapped==0 or hi-1<=1 -> DONE; else PASS.
//   DONE  : done=1. Outputs hold until the next start edge, which goes to LOADN and drops done.
// - j and hi compare in AW+1 bits, so N=2^AW-1 (last address 2^AW-1) does not wrap.
// - cycles increments once per clk in LOADN..NEXT (start-edge clk excluded) and saturates at all-ones.
//   swaps also saturates at all-ones.
// - Equal elements are never swapped, so the sort is stable.
// - A DONE->LOADN restart clears the stats in LOADN; the previous values stay visible until then.
// TESTING
// 1 N=4 {4,3,2,1}, ascending, unsigned -> RAM {1,2,3,4}, swaps=6, done=1.
// 2 N=4 {1,2,3,4}, ascending -> a single pass with no writes; swaps=0, cycles=14.
// 3 N=2 {0xFFFFFFFF,1}, ascending: is_signed=1 -> unchanged, swaps=0, cycles=6;
//   is_signed=0 -> {1,0xFFFFFFFF}, swaps=1, cycles=8.
// 4 N=3 {1,3,2}, descend=1 -> {3,2,1}. N=0 and N=1 -> DONE after LOADN with cycles=1 and no RAM writes.
// 5 Pulse dbg_we=1 to addr 1 while busy -> the write is ignored. In DONE, a dbg write and read-back of addr 1 succeed.
//   A second start edge while busy is ignored.
// 6 Assert rstn during WR_B -> busy=0, done=0, cycles=0 next clk.
//   A fresh start then sorts correctly from the partial state.

Source files
------------

// File: rtl/sort_engine.sv
// In-place bubble sort with early exit over an external single-port RAM.
// Word 0 holds N and the elements sit at 1..N; a debug port owns the RAM whenever the engine is idle.
module sort_engine #(
  parameter int DW = 32,
  parameter int AW = 9,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          descend,
  input  logic          is_signed,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycles,
  output logic [CW-1:0] swaps,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_we,
  output logic [DW-1:0] dbg_rdata
);

  typedef enum logic [3:0] {
    IDLE, LOADN, PASS, RD_A, RD_B, CMP, WR_A, WR_B, NEXT, DONE
  } state_t;

  state_t        state, state_nx;
  logic          start_d, desc_r, sgn_r, swapped;
  logic [AW:0]   j, hi, j_inc, hi_m1, n_rd;
  logic [DW-1:0] a_r, b_r;
  logic [AW-1:0] fsm_addr;
  logic [DW-1:0] fsm_wdata;
  logic          fsm_we, start_edge, ooo;

  function automatic logic out_of_order(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                        input logic dsc, input logic sgn);
    logic gt_xy, gt_yx;
    gt_xy = sgn ? ($signed(x) > $signed(y)) : (x > y);
    gt_yx = sgn ? ($signed(y) > $signed(x)) : (y > x);
    return dsc ? gt_yx : gt_xy;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Indices carry one extra bit so the last pair at address 2^AW-1 never wraps.
  assign start_edge = start & ~start_d;
  assign j_inc      = j + (AW+1)'(1);
  assign hi_m1      = hi - (AW+1)'(1);
  assign n_rd       = {1'b0, mem_rdata[AW-1:0]};
  assign ooo        = out_of_order(a_r, b_r, desc_r, sgn_r);
  assign dbg_rdata  = mem_rdata;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start_edge) state_nx = LOADN;
      LOADN:      state_nx = (n_rd <= (AW+1)'(1)) ? DONE : PASS;
      PASS:       state_nx = RD_A;
      RD_A:       state_nx = RD_B;
      RD_B:       state_nx = CMP;
      CMP:        state_nx = ooo ? WR_A : NEXT;
      WR_A:       state_nx = WR_B;
      WR_B:       state_nx = NEXT;
      NEXT: begin
        if (j_inc < hi)                              state_nx = RD_A;
        else if (!swapped || hi_m1 <= (AW+1)'(1))    state_nx = DONE;
        else                                         state_nx = PASS;
      end
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE) && (state != DONE);
    done      = (state == DONE);
    fsm_addr  = '0;
    fsm_wdata = '0;
    fsm_we    = 1'b0;
    case (state)
      RD_A: fsm_addr = j[AW-1:0];
      RD_B: fsm_addr = j_inc[AW-1:0];
      WR_A: begin fsm_addr = j[AW-1:0];     fsm_wdata = b_r; fsm_we = 1'b1; end
      WR_B: begin fsm_addr = j_inc[AW-1:0]; fsm_wdata = a_r; fsm_we = 1'b1; end
      default: ;
    endcase
    mem_addr  = busy ? fsm_addr  : dbg_addr;
    mem_wdata = busy ? fsm_wdata : dbg_wdata;
    mem_we    = busy ? fsm_we    : dbg_we;
  end

  // Datapath and statistics; LOADN counts itself, hence the restart value of 1.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      start_d <= 1'b0;
      desc_r  <= 1'b0;
      sgn_r   <= 1'b0;
      j       <= '0;
      hi      <= '0;
      a_r     <= '0;
      b_r     <= '0;
      swapped <= 1'b0;
      cycles  <= '0;
      swaps   <= '0;
    end else begin
      start_d <= start;
      if (busy) cycles <= sat_inc(cycles);
      case (state)
        IDLE, DONE: if (start_edge) begin
          desc_r <= descend;
          sgn_r  <= is_signed;
        end
        LOADN: begin
          hi     <= n_rd;
          cycles <= CW'(1);
          swaps  <= '0;
        end
        PASS: begin
          j       <= (AW+1)'(1);
          swapped <= 1'b0;
        end
        RD_A: a_r <= mem_rdata;
        RD_B: b_r <= mem_rdata;
        WR_B: begin
          swapped <= 1'b1;
          swaps   <= sat_inc(swaps);
        end
        NEXT: begin
          if (j_inc < hi) j  <= j_inc;
          else            hi <= hi_m1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_engine.sv
// Bench for sort_engine: a RAM model, randomized sorts against a bubble-sort reference,
// and a scoreboard monitor that checks RAM and statistics on every done edge.
module tb_sort_engine;
  localparam int DW = 32, AW = 9, CW = 16, MAXL = 16;

  logic          clk = 1'b0, rstn = 1'b1, start = 1'b0, descend = 1'b0, is_signed = 1'b0;
  logic          busy, done, mem_we, dbg_we = 1'b0;
  logic [CW-1:0] cycles, swaps;
  logic [AW-1:0] mem_addr, dbg_addr = '0;
  logic [DW-1:0] mem_wdata, mem_rdata, dbg_rdata, dbg_wdata = '0;
  logic [DW-1:0] ram [0:(1<<AW)-1];

  typedef struct {
    int            len;
    logic [DW-1:0] v [MAXL];
    int            sw;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0, checks = 0;
  logic done_prev = 1'b0;

  sort_engine #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .descend(descend), .is_signed(is_signed),
    .busy(busy), .done(done), .cycles(cycles), .swaps(swaps),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic gt(input logic [DW-1:0] x, input logic [DW-1:0] y, input bit s);
    return s ? ($signed(x) > $signed(y)) : (x > y);
  endfunction

  // Reference: bubble sort with a shrinking bound and early exit, costing each step in clocks.
  function automatic exp_t model(input logic [DW-1:0] vin[MAXL], input int len, input int n,
                                 input bit d, input bit s);
    exp_t          e;
    logic [DW-1:0] t;
    int            hi;
    bit            any, swp;
    e.len = len; e.v = vin; e.sw = 0; e.cyc = 1;
    if (n > 1) begin
      hi = n;
      do begin
        any = 0;
        e.cyc += 1;
        for (int k = 0; k + 1 < hi; k++) begin
          e.cyc += 4;
          swp = d ? gt(e.v[k+1], e.v[k], s) : gt(e.v[k], e.v[k+1], s);
          if (swp) begin
            t = e.v[k]; e.v[k] = e.v[k+1]; e.v[k+1] = t;
            e.sw += 1; e.cyc += 2; any = 1;
          end
        end
        hi--;
      end while (any && hi > 1);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_done", DW'(1), DW'(0));
      end else begin
        int mis;
        mon_e = sb.pop_front();
        mis = 0;
        for (int k = mon_e.len - 1; k >= 0; k--)
          if (ram[k+1] !== mon_e.v[k]) mis = k;
        check($sformatf("array[%0d]", mis + 1), ram[mis+1], mon_e.v[mis]);
        check("swaps", DW'(swaps), DW'(mon_e.sw));
        check("cycles", DW'(cycles), DW'(mon_e.cyc));
      end
    end
    done_prev = done;
  end

  task automatic wr_dbg(input int addr, input logic [DW-1:0] d);
    @(negedge clk);
    dbg_addr = AW'(addr); dbg_wdata = d; dbg_we = 1'b1;
    @(negedge clk);
    dbg_we = 1'b0;
  endtask

  task automatic pulse_start(input bit d, input bit s);
    @(negedge clk);
    descend = d; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; descend = ~d; is_signed = ~s;
  endtask

  task automatic run_sort(input logic [DW-1:0] vals[MAXL], input int len, input int n,
                          input bit d, input bit s, input bit poke);
    int cnt;
    wr_dbg(0, DW'(n));
    for (int k = 0; k < len; k++) wr_dbg(k + 1, vals[k]);
    sb.push_back(model(vals, len, n, d, s));
    pulse_start(d, s);
    if (poke) begin
      repeat (3) @(negedge clk);
      dbg_addr = AW'(1); dbg_wdata = 32'hDEAD_BEEF; dbg_we = 1'b1; start = 1'b1;
      @(negedge clk);
      dbg_we = 1'b0; start = 1'b0;
    end
    cnt = 0;
    while (!done && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check("done_reached", DW'(done), DW'(1));
    @(negedge clk);
  endtask

  logic [DW-1:0] vals [MAXL];
  logic [DW-1:0] snap [MAXL];

  initial begin
    int cnt, len;
    for (int k = 0; k < MAXL; k++) begin vals[k] = '0; snap[k] = '0; end
    repeat (2) @(negedge clk);
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_cycles", DW'(cycles), DW'(0));
    check("rst_swaps", DW'(swaps), DW'(0));
    check("rst_mem_we", DW'(mem_we), DW'(0));
    rstn = 1'b0;

    for (int k = 0; k < 4; k++) vals[k] = DW'(4 - k);
    run_sort(vals, 4, 4, 0, 0, 0);
    for (int k = 0; k < 4; k++) vals[k] = DW'(k + 1);
    run_sort(vals, 4, 4, 0, 0, 0);
    vals[0] = 32'hFFFF_FFFF; vals[1] = 32'd1;
    run_sort(vals, 2, 2, 0, 1, 0);
    vals[0] = 32'hFFFF_FFFF; vals[1] = 32'd1;
    run_sort(vals, 2, 2, 0, 0, 0);
    vals[0] = 32'd1; vals[1] = 32'd3; vals[2] = 32'd2;
    run_sort(vals, 3, 3, 1, 0, 0);
    vals[0] = 32'd7; vals[1] = 32'd3;
    run_sort(vals, 2, 0, 0, 0, 0);
    run_sort(vals, 2, 1, 0, 0, 0);

    // Debug write and a second start edge while busy must both be ignored.
    for (int k = 0; k < 8; k++) vals[k] = DW'(8 - k);
    run_sort(vals, 8, 8, 0, 0, 1);
    wr_dbg(1, 32'h1234_5678);
    dbg_addr = AW'(1);
    #1 check("dbg_readback", dbg_rdata, 32'h1234_5678);

    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(2, 12);
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 2))
          0:       vals[k] = $urandom;
          1:       vals[k] = DW'($urandom_range(0, 5));
          default: vals[k] = DW'($urandom_range(0, 8)) - 32'd4;
        endcase
      end
      run_sort(vals, len, len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    // Reset in the middle of a swap, then sort whatever the RAM holds.
    for (int k = 0; k < 6; k++) vals[k] = DW'(6 - k);
    wr_dbg(0, DW'(6));
    for (int k = 0; k < 6; k++) wr_dbg(k + 1, vals[k]);
    pulse_start(0, 0);
    cnt = 0;
    while (!mem_we && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_wr_a", DW'(mem_we), DW'(1));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_busy", DW'(busy), DW'(0));
    check("midrst_done", DW'(done), DW'(0));
    check("midrst_cycles", DW'(cycles), DW'(0));
    rstn = 1'b0;
    for (int k = 0; k < 6; k++) snap[k] = ram[k+1];
    run_sort(snap, 6, 6, 0, 0, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", DW'(sb.size()), DW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
